round_ctrl: RTL

Game-round sequencer for the two-tank arena, clocked once per video frame.
- Drives the Reset input of both tank modules.
- Gates tank movement.
- Runs the pre-round countdown and the post-hit delay.
- Keeps the score for both players and declares the winner.
Sits between the keyboard/hit-detection logic and the tank_one instances.

---
 rtl/round_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/round_ctrl.sv
// Round sequencer for the two-tank arena: spawn, countdown, play, post-hit delay, scoring.
// Advances once per video frame on frame_clk.
module round_ctrl #(
    parameter int START_FRAMES = 60,
    parameter int END_FRAMES   = 120,
    parameter int CNT_W        = 8,
    parameter int MAX_SCORE    = 5
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             start_req,
    input  logic             hit_one,
    input  logic             hit_two,
    output logic             tank_reset,
    output logic             move_en,
    output logic [3:0]       score_one,
    output logic [3:0]       score_two,
    output logic [1:0]       winner,
    output logic [CNT_W-1:0] frames_left,
    output logic [2:0]       state_out
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SPAWN     = 3'd1,
        S_COUNTDOWN = 3'd2,
        S_PLAY      = 3'd3,
        S_ROUND_END = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_FRAMES - 1);
    localparam logic [CNT_W-1:0] END_LOAD   = CNT_W'(END_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       MAX_SC     = 4'(MAX_SCORE);

    state_t           state_reg, state_next;
    logic [3:0]       score_one_reg, score_one_next;
    logic [3:0]       score_two_reg, score_two_next;
    logic [1:0]       winner_reg, winner_next;
    logic [CNT_W-1:0] frames_left_reg, frames_left_next;
    logic             start_req_q_reg;
    logic             start_pulse;

    assign start_pulse = start_req & ~start_req_q_reg;

    always_comb begin
        state_next       = state_reg;
        score_one_next   = score_one_reg;
        score_two_next   = score_two_reg;
        winner_next      = winner_reg;
        frames_left_next = frames_left_reg;
        case (state_reg)
            S_IDLE, S_GAME_OVER: begin
                if (start_pulse) begin
                    score_one_next = 4'd0;
                    score_two_next = 4'd0;
                    winner_next    = 2'd0;
                    state_next     = S_SPAWN;
                end
            end
            S_SPAWN: begin
                frames_left_next = START_LOAD;
                state_next       = S_COUNTDOWN;
            end
            S_COUNTDOWN: begin
                if (frames_left_reg != '0)
                    frames_left_next = frames_left_reg - CNT_ONE;
                else
                    state_next = S_PLAY;
            end
            S_PLAY: begin
                frames_left_next = '0;
                if (hit_one || hit_two) begin
                    frames_left_next = END_LOAD;
                    state_next       = S_ROUND_END;
                    if (hit_one && hit_two) begin
                        winner_next = 2'd3;
                    end else if (hit_one) begin
                        winner_next    = 2'd2;
                        score_two_next = (score_two_reg >= MAX_SC) ? score_two_reg
                                                                   : score_two_reg + 4'd1;
                    end else begin
                        winner_next    = 2'd1;
                        score_one_next = (score_one_reg >= MAX_SC) ? score_one_reg
                                                                   : score_one_reg + 4'd1;
                    end
                end
            end
            S_ROUND_END: begin
                if (frames_left_reg != '0)
                    frames_left_next = frames_left_reg - CNT_ONE;
                else if (score_one_reg == MAX_SC || score_two_reg == MAX_SC)
                    state_next = S_GAME_OVER;
                else
                    state_next = S_SPAWN;
            end
            default: begin
                state_next       = S_IDLE;
                score_one_next   = 4'd0;
                score_two_next   = 4'd0;
                winner_next      = 2'd0;
                frames_left_next = '0;
            end
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_reg       <= S_IDLE;
            score_one_reg   <= 4'd0;
            score_two_reg   <= 4'd0;
            winner_reg      <= 2'd0;
            frames_left_reg <= '0;
            // Track the key level during reset so a key held across release is not seen as a press.
            start_req_q_reg <= start_req;
        end else begin
            state_reg       <= state_next;
            score_one_reg   <= score_one_next;
            score_two_reg   <= score_two_next;
            winner_reg      <= winner_next;
            frames_left_reg <= frames_left_next;
            start_req_q_reg <= start_req;
        end
    end

    assign tank_reset  = Reset | (state_reg == S_IDLE) | (state_reg == S_SPAWN);
    assign move_en     = ~Reset & (state_reg == S_PLAY);
    assign score_one   = score_one_reg;
    assign score_two   = score_two_reg;
    assign winner      = winner_reg;
    assign frames_left = frames_left_reg;
    assign state_out   = state_reg;

endmodule
